uart_fifo_ctrl: RTL and testbench



---
 rtl/uart_fifo_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: synchronous FIFO with occupancy and threshold flags for the UART TX/RX paths.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow registers.
//
// state   | meaning
// EMPTY   | count == 0, reads are rejected
// PARTIAL | 0 < count < depth
// FULL    | count == depth, a write is accepted only alongside a read
module uart_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = (1 << ADDR_W) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = (ADDR_W > 0) ? ADDR_W : 1;
    localparam int CW    = ADDR_W + 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [PW-1:0]     w_ptr_q, w_ptr_d;
    logic [PW-1:0]     r_ptr_q, r_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              r_valid_q, r_valid_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    logic              wr_acc, rd_acc;

    // Acceptance looks only at registered flags, so it is stable for the whole cycle.
    always_comb begin
        wr_acc = wr & (~full_q | rd);
        rd_acc = rd & ~empty_q;
    end

    always_comb begin
        count_d   = count_q + CW'(wr_acc) - CW'(rd_acc);
        w_ptr_d   = w_ptr_q;
        r_ptr_d   = r_ptr_q;
        r_data_d  = r_data_q;
        r_valid_d = rd_acc;

        if (wr_acc) begin
            w_ptr_d = (w_ptr_q == PTR_LAST) ? '0 : w_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            r_ptr_d  = (r_ptr_q == PTR_LAST) ? '0 : r_ptr_q + PW'(1);
            r_data_d = mem[r_ptr_q];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (wr_acc) begin
                    state_d = (count_d == DEPTH_C) ? ST_FULL : ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (count_d == DEPTH_C) begin
                    state_d = ST_FULL;
                end else if (count_d == '0) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (rd_acc && !wr_acc) begin
                    state_d = (count_d == '0) ? ST_EMPTY : ST_PARTIAL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        full_d  = (state_d == ST_FULL);
        empty_d = (state_d == ST_EMPTY);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            w_ptr_q   <= '0;
            r_ptr_q   <= '0;
            count_q   <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            w_ptr_q   <= w_ptr_d;
            r_ptr_q   <= r_ptr_d;
            count_q   <= count_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
        end
    end

    // Storage has no reset; when full, a paired write lands in the slot being read out.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[w_ptr_q] <= w_data;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr && !wr_acc) begin
            ovf_d = 1'b1;
        end
        if (rd && !rd_acc) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    logic clr_err_unused;
    assign clr_err_unused = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

    assign r_data       = r_data_q;
    assign r_valid      = r_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: queue-based reference model compared every
// cycle, plus hand-computed literal checks along the directed sequence.
module tb_uart_fifo_ctrl;

    localparam int DEPTH = 16;
`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [7:0] r_data;
    logic       r_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    uart_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue holding the FIFO contents in order.
    logic [7:0] mq[$];
    logic [7:0] m_rdata = 8'h00;
    bit         m_rvalid = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    bit         m_wa, m_ra, m_oset, m_uset;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_rdata  = 8'h00;
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
        end else begin
            m_ra   = rd && (mq.size() != 0);
            m_wa   = wr && ((mq.size() < DEPTH) || rd);
            m_oset = wr && !m_wa;
            m_uset = rd && !m_ra;
            m_rvalid = m_ra;
            if (m_ra) m_rdata = mq.pop_front();
            if (m_wa) mq.push_back(w_data);
            if (clr_err) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (m_oset) m_ovf = 1'b1;
            if (m_uset) m_udf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",        int'(count),    mq.size());
            chk("empty",        int'(empty),    int'(mq.size() == 0));
            chk("full",         int'(full),     int'(mq.size() == DEPTH));
            chk("almost_full",  int'(almost_full),  int'(mq.size() >= DEPTH - 2));
            chk("almost_empty", int'(almost_empty), int'(mq.size() <= 2));
            chk("r_valid",      int'(r_valid),  int'(m_rvalid));
            chk("r_data",       int'(r_data),   int'(m_rdata));
            chk("overflow",     int'(overflow), int'(ERR_EN & m_ovf));
            chk("underflow",    int'(underflow), int'(ERR_EN & m_udf));
        end
    end

    task automatic step(input logic w, input logic r, input logic [7:0] d,
                        input logic c, input logic rst);
        wr      = w;
        rd      = r;
        w_data  = d;
        clr_err = c;
        reset   = rst;
        @(posedge clk);
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
        reset   = 1'b0;
    endtask

    initial begin
        step(0, 0, 8'h00, 0, 1);
        chk_en = 1'b1;
        step(0, 0, 8'h00, 0, 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_ae",    int'(almost_empty), 1);
        chk("rst_rdata", int'(r_data), 8'h00);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'(i), 0, 0);
            if (i == 12) chk("af_at13", int'(almost_full), 0);
            if (i == 13) chk("af_at14", int'(almost_full), 1);
        end
        chk("fill_full",  int'(full), 1);
        chk("fill_count", int'(count), 16);
        step(1, 0, 8'hAA, 0, 0);
        chk("drop_count", int'(count), 16);
        chk("drop_ovf",   int'(overflow), int'(ERR_EN));

        // Drain 16
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'h00, 0, 0);
            chk("drain_rvalid", int'(r_valid), 1);
            chk("drain_rdata",  int'(r_data), i);
        end
        chk("drain_empty", int'(empty), 1);
        step(0, 1, 8'h00, 0, 0);
        chk("extra_rdata", int'(r_data), 8'h0F);
        chk("extra_rvalid", int'(r_valid), 0);
        chk("extra_udf", int'(underflow), int'(ERR_EN));
        step(0, 0, 8'h00, 1, 0);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_udf", int'(underflow), 0);

        // Full with simultaneous read/write, then drain across the wrap
        for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 8'(8'h10 + i), 0, 0);
            chk("fullrw_rdata", int'(r_data), i);
            chk("fullrw_full",  int'(full), 1);
            chk("fullrw_count", int'(count), 16);
            chk("fullrw_ovf",   int'(overflow), 0);
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'h00, 0, 0);
            chk("wrap_rdata", int'(r_data), (i < 12) ? (4 + i) : (8'h10 + i - 12));
        end

        // Empty with simultaneous read/write
        step(1, 1, 8'h5A, 0, 0);
        chk("emptyrw_count",  int'(count), 1);
        chk("emptyrw_rvalid", int'(r_valid), 0);
        chk("emptyrw_udf",    int'(underflow), int'(ERR_EN));
        step(0, 1, 8'h00, 0, 0);
        chk("emptyrw_rdata",  int'(r_data), 8'h5A);
        chk("emptyrw_rv2",    int'(r_valid), 1);

        // Reset mid-operation with a write pending
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h30 + i), 0, 0);
        chk("pre_rst_count", int'(count), 5);
        step(1, 0, 8'hEE, 0, 1);
        chk("midrst_count", int'(count), 0);
        chk("midrst_empty", int'(empty), 1);
        chk("midrst_udf",   int'(underflow), 0);
        chk("midrst_rdata", int'(r_data), 8'h00);
        step(0, 1, 8'h00, 0, 0);
        chk("postrst_rvalid", int'(r_valid), 0);
        chk("postrst_udf",    int'(underflow), int'(ERR_EN));
        step(0, 0, 8'h00, 0, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
